// File: rtl/scale_ctrl.sv
// scale_ctrl: turns debounced up/down buttons and a parallel load into the
// divider scale word, and pulses the divider's active-low reload after every change.
//
// Ports:
//   clk_in   system clock (shared with the divider)
//   rst      synchronous active-high reset
//   btn_up   raw asynchronous button, steps scale up
//   btn_down raw asynchronous button, steps scale down
//   load_en  single-cycle strobe loading load_val
//   load_val value loaded on load_en
//   scale    current scale word
//   div_nrst active-low reload to the divider
//   busy     high while a reload is in progress
module scale_ctrl #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RELOAD_CYCLES   = 2,
  parameter int INIT_SCALE      = 0
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] scale,
  output logic             div_nrst,
  output logic             busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = (RELOAD_CYCLES > 1) ? $clog2(RELOAD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RCNT_LAST = RW'(RELOAD_CYCLES - 1);
  localparam logic [WIDTH-1:0] SCALE_MAX = '1;

  typedef enum logic {
    S_IDLE,
    S_RELOAD
  } state_e;

  // bit 0 = up, bit 1 = down
  logic [1:0] s1_q, s1_d;
  logic [1:0] s2_q, s2_d;
  logic [1:0] db_q, db_d;
  logic [1:0] dbp_q, dbp_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0] step;

  logic [WIDTH-1:0] scale_q, scale_d;
  logic upd;

  state_e state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  // Set by reset so the first post-reset edge starts the reload count.
  logic init_q, init_d;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      db_q    <= '0;
      dbp_q   <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      scale_q <= WIDTH'(INIT_SCALE);
      state_q <= S_RELOAD;
      rcnt_q  <= '0;
      init_q  <= 1'b1;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      db_q    <= db_d;
      dbp_q   <= dbp_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      scale_q <= scale_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      init_q  <= init_d;
    end
  end

  always_comb begin
    s1_d  = {btn_down, btn_up};
    s2_d  = s1_q;
    db_d  = db_q;
    dbp_d = db_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    step = db_q & ~dbp_q;
  end

  always_comb begin
    scale_d = scale_q;
    upd     = 1'b0;
    if (load_en) begin
      scale_d = load_val;
      upd     = 1'b1;
    end else if (step[0] && step[1]) begin
      upd = 1'b0;
    end else if (step[0]) begin
      if (scale_q != SCALE_MAX) begin
        scale_d = scale_q + WIDTH'(1);
        upd     = 1'b1;
      end
    end else if (step[1]) begin
      if (scale_q != '0) begin
        scale_d = scale_q - WIDTH'(1);
        upd     = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    init_d  = 1'b0;
    if (upd || init_q) begin
      state_d = S_RELOAD;
      rcnt_d  = '0;
    end else if (state_q == S_RELOAD) begin
      if (rcnt_q == RCNT_LAST) begin
        state_d = S_IDLE;
      end else begin
        rcnt_d = rcnt_q + RW'(1);
      end
    end
  end

  always_comb begin
    scale    = scale_q;
    div_nrst = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_scale_ctrl.sv
// tb_scale_ctrl: directed checks of scale_ctrl with short debounce/reload
// settings and a small model of the divider's scale capture.
module tb_scale_ctrl;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       load_en = 1'b0;
  logic [7:0] load_val = '0;
  logic [7:0] scale;
  logic       div_nrst;
  logic       busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] div_lat = '0;

  scale_ctrl #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(4),
    .RELOAD_CYCLES(2),
    .INIT_SCALE(0)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .load_en(load_en),
    .load_val(load_val),
    .scale(scale),
    .div_nrst(div_nrst),
    .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  // divider captures scale while its nrst is low
  always @(posedge clk_in) begin
    if (div_nrst === 1'b0) div_lat <= scale;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [7:0] v);
    load_en = 1'b1;
    load_val = v;
    tick();
    load_en = 1'b0;
    idle(3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (scale !== 8'd0 || div_nrst !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL reset_hold: scale=%0d nrst=%b busy=%b want 0/0/1",
                 scale, div_nrst, busy);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (div_nrst !== (k == 3) || busy !== (k != 3)) begin
        failures++;
        $display("FAIL reset_release k=%0d: nrst=%b busy=%b want nrst=%b",
                 k, div_nrst, busy, (k == 3));
      end
    end
    checks++;
    if (div_lat !== 8'd0) begin
      failures++;
      $display("FAIL reset_latch: got %0d want 0", div_lat);
    end
  endtask

  task automatic test_clean_press();
    logic [7:0] es;
    logic en;
    btn_up = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      es = (k >= 7) ? 8'd1 : 8'd0;
      en = !(k == 7 || k == 8);
      checks++;
      if (scale !== es || div_nrst !== en) begin
        failures++;
        $display("FAIL clean_press k=%0d: scale=%0d nrst=%b want %0d/%b",
                 k, scale, div_nrst, es, en);
      end
    end
    btn_up = 1'b0;
    idle(12);
    checks++;
    if (scale !== 8'd1 || div_nrst !== 1'b1) begin
      failures++;
      $display("FAIL clean_release: scale=%0d nrst=%b want 1/1",
               scale, div_nrst);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] es;
    logic en;
    do_load(8'd5);
    for (int i = 0; i < 12; i++) begin
      btn_down = ((i % 4) < 2);
      tick();
      checks++;
      if (scale !== 8'd5 || div_nrst !== 1'b1) begin
        failures++;
        $display("FAIL bounce_glitch i=%0d: scale=%0d nrst=%b want 5/1",
                 i, scale, div_nrst);
      end
    end
    btn_down = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      es = (k >= 7) ? 8'd4 : 8'd5;
      en = !(k == 7 || k == 8);
      checks++;
      if (scale !== es || div_nrst !== en) begin
        failures++;
        $display("FAIL bounce_settle k=%0d: scale=%0d nrst=%b want %0d/%b",
                 k, scale, div_nrst, es, en);
      end
    end
    btn_down = 1'b0;
    idle(10);
    checks++;
    if (scale !== 8'd4) begin
      failures++;
      $display("FAIL bounce_final: scale=%0d want 4", scale);
    end
  endtask

  task automatic test_saturation();
    do_load(8'd255);
    btn_up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (scale !== 8'd255 || div_nrst !== 1'b1) begin
        failures++;
        $display("FAIL sat_up k=%0d: scale=%0d nrst=%b want 255/1",
                 k, scale, div_nrst);
      end
    end
    btn_up = 1'b0;
    idle(10);
    do_load(8'd0);
    btn_down = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (scale !== 8'd0 || div_nrst !== 1'b1) begin
        failures++;
        $display("FAIL sat_down k=%0d: scale=%0d nrst=%b want 0/1",
                 k, scale, div_nrst);
      end
    end
    btn_down = 1'b0;
    idle(10);
  endtask

  task automatic test_priority();
    btn_up = 1'b1;
    idle(6);
    load_en = 1'b1;
    load_val = 8'h40;
    tick();
    load_en = 1'b0;
    checks++;
    if (scale !== 8'h40 || div_nrst !== 1'b0) begin
      failures++;
      $display("FAIL prio_load: scale=%0h nrst=%b want 40/0",
               scale, div_nrst);
    end
    idle(10);
    checks++;
    if (scale !== 8'h40 || div_nrst !== 1'b1) begin
      failures++;
      $display("FAIL prio_after: scale=%0h nrst=%b want 40/1",
               scale, div_nrst);
    end
    btn_up = 1'b0;
    idle(10);
  endtask

  task automatic test_collision();
    btn_up = 1'b1;
    btn_down = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (scale !== 8'h40 || div_nrst !== 1'b1) begin
        failures++;
        $display("FAIL collision k=%0d: scale=%0h nrst=%b want 40/1",
                 k, scale, div_nrst);
      end
    end
    btn_up = 1'b0;
    btn_down = 1'b0;
    idle(10);
  endtask

  task automatic test_back_to_back();
    load_en = 1'b1;
    load_val = 8'd10;
    tick();
    checks++;
    if (scale !== 8'd10 || div_nrst !== 1'b0) begin
      failures++;
      $display("FAIL retrig_first: scale=%0d nrst=%b want 10/0",
               scale, div_nrst);
    end
    load_val = 8'd20;
    tick();
    load_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      checks++;
      if (scale !== 8'd20 || div_nrst !== (k == 2)) begin
        failures++;
        $display("FAIL retrig k=%0d: scale=%0d nrst=%b want 20/%b",
                 k, scale, div_nrst, (k == 2));
      end
    end
    checks++;
    if (div_lat !== 8'd20) begin
      failures++;
      $display("FAIL retrig_latch: got %0d want 20", div_lat);
    end
    load_en = 1'b1;
    load_val = 8'd20;
    tick();
    load_en = 1'b0;
    checks++;
    if (div_nrst !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL same_value_load: nrst=%b busy=%b want 0/1",
               div_nrst, busy);
    end
    idle(3);
    checks++;
    if (div_nrst !== 1'b1 || scale !== 8'd20) begin
      failures++;
      $display("FAIL same_value_end: scale=%0d nrst=%b want 20/1",
               scale, div_nrst);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_saturation();
    test_priority();
    test_collision();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
